// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// stage indices and default flush length.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StFlush = 2'd2
  } hz_state_e;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  localparam int unsigned FLUSH_CYCLES_DEF = 2;

  // Flush counter is wide enough for FLUSH_CYCLES up to 7.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_prop.sv
// Suffix-OR of per-stage stall requests: a stalled stage holds every younger
// stage behind it. Purely combinational; also used by the debug unit.
module hazard_stall_prop #(
  parameter int unsigned STAGES = 5
) (
  input  logic [STAGES-1:0] stall_req_i,
  output logic [STAGES-1:0] stall_o
);

  // Walk from WB down to IF accumulating any older-stage request.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    stall_o = '0;
    for (int j = int'(STAGES) - 1; j >= 0; j--) begin
      acc        = acc | stall_req_i[j];
      stall_o[j] = acc;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core.
// Optional performance counters are enabled with PIPE_HAZARD_PERF_EN.
// Exception/ERET entry asserts a full flush in the accepting cycle (Mealy) and
// then holds it in FLUSH so the delayed paths in the delivery registers settle.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STAGES       = 5,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_vector,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] br_target,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  // EX index and the stages younger than EX that a branch redirect flushes.
  localparam int unsigned       ExIdx     = STAGES - 3;
  localparam logic [STAGES-1:0] AllOnes   = '1;
  localparam logic [STAGES-1:0] FrontMask = STAGES'((1 << ExIdx) - 1);
  localparam logic [CNT_W-1:0]  CntLoad   = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [STAGES-1:0] stall_prop;
  logic              evt;
  logic              memwb_busy;
  logic [ADDR_W-1:0] evt_pc;
  logic              enter_flush;
  logic              br_take;
  logic [STAGES-1:0] stall_raw;

  hazard_stall_prop #(
    .STAGES (STAGES)
  ) u_stall_prop (
    .stall_req_i (stall_req),
    .stall_o     (stall_prop)
  );

  assign evt        = exc_req | eret_req;
  assign memwb_busy = |stall_req[STAGES-1:STAGES-2];
  // Exception wins over ERET when both commit together.
  assign evt_pc     = exc_req ? exc_vector : epc;

  // State, latched redirect PC and flush counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; also flags flush entry and accepted branch redirects.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    enter_flush = 1'b0;
    br_take     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (evt) begin
          pc_d = evt_pc;
          if (!memwb_busy) begin
            state_d     = StFlush;
            cnt_d       = CntLoad;
            enter_flush = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else if (br_redirect && !stall_prop[ExIdx]) begin
          br_take = 1'b1;
        end
      end
      StWait: begin
        if (!memwb_busy) begin
          state_d     = StFlush;
          cnt_d       = CntLoad;
          enter_flush = 1'b1;
        end
      end
      StFlush: begin
        // The entry cycle already flushed, so leave once the count is spent.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode; combinational outputs are held low while in reset.
  always_comb begin
    stall_raw      = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      redirect_pc = pc_q;
      unique case (state_q)
        StIdle: begin
          stall_raw = stall_prop;
          if (enter_flush) begin
            flush          = AllOnes;
            redirect_valid = 1'b1;
            redirect_pc    = evt_pc;
          end else if (br_take) begin
            flush          = FrontMask;
            redirect_valid = 1'b1;
            redirect_pc    = br_target;
          end
        end
        StWait: begin
          stall_raw = AllOnes;
          if (enter_flush) begin
            flush          = AllOnes;
            redirect_valid = 1'b1;
          end
        end
        StFlush: begin
          flush = AllOnes;
        end
        default: begin
          flush = '0;
        end
      endcase
    end
    // Flush overrides stall on the same stage.
    stall = stall_raw & ~flush;
  end

  assign busy = (state_q != StIdle);

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_redir_q, perf_redir_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(stall[0]);
    perf_flush_d = perf_flush_q + 32'(enter_flush);
    perf_redir_d = perf_redir_q + 32'(br_take);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_stall_cnt    = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
  assign perf_redirect_cnt = perf_redir_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table of single-cycle IDLE
// cases, then hand-written exception, WAIT, priority and reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned STAGES = 5;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [STAGES-1:0] stall_req;
  logic              exc_req;
  logic [ADDR_W-1:0] exc_vector;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  logic              br_redirect;
  logic [ADDR_W-1:0] br_target;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
  logic [31:0]       perf_redirect_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(
    .STAGES       (STAGES),
    .FLUSH_CYCLES (2),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_req         (stall_req),
    .exc_req           (exc_req),
    .exc_vector        (exc_vector),
    .eret_req          (eret_req),
    .epc               (epc),
    .br_redirect       (br_redirect),
    .br_target         (br_target),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .busy              (busy)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  stall_req;
    logic        br;
    logic [31:0] target;
    logic [4:0]  exp_stall;
    logic [4:0]  exp_flush;
    logic        exp_rv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_stall, input logic [4:0] e_flush,
                         input logic e_rv, input logic [31:0] e_pc, input logic e_busy);
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    chk({tag, ".rv"}, 32'(redirect_valid), 32'(e_rv));
    chk({tag, ".pc"}, redirect_pc, e_pc);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    stall_req   = '0;
    exc_req     = 1'b0;
    eret_req    = 1'b0;
    br_redirect = 1'b0;
    exc_vector  = '0;
    epc         = '0;
    br_target   = '0;
  endtask

  initial begin
    vecs[0] = '{5'b00100, 1'b0, 32'h0,        5'b00111, 5'b00000, 1'b0, 32'h0};
    vecs[1] = '{5'b10000, 1'b0, 32'h0,        5'b11111, 5'b00000, 1'b0, 32'h0};
    vecs[2] = '{5'b00001, 1'b0, 32'h0,        5'b00001, 5'b00000, 1'b0, 32'h0};
    vecs[3] = '{5'b01010, 1'b0, 32'h0,        5'b01111, 5'b00000, 1'b0, 32'h0};
    vecs[4] = '{5'b00000, 1'b1, 32'h80001000, 5'b00000, 5'b00011, 1'b1, 32'h80001000};
    vecs[5] = '{5'b00100, 1'b1, 32'h80001000, 5'b00111, 5'b00000, 1'b0, 32'h0};
    vecs[6] = '{5'b00010, 1'b1, 32'h80002000, 5'b00000, 5'b00011, 1'b1, 32'h80002000};
    vecs[7] = '{5'b10000, 1'b1, 32'h80003000, 5'b11111, 5'b00000, 1'b0, 32'h0};

    idle_inputs();
    rst = 1'b1;
    step();
    // Combinational outputs must be held low during reset even with requests.
    stall_req   = 5'b10000;
    br_redirect = 1'b1;
    br_target   = 32'h1234_5678;
    settle();
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.rv", 32'(redirect_valid), 32'h0);
    step();
    rst = 1'b0;
    idle_inputs();
    settle();
    chk_out("reset_state", 5'b0, 5'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step();
      stall_req   = vecs[i].stall_req;
      br_redirect = vecs[i].br;
      br_target   = vecs[i].target;
      settle();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush, vecs[i].exp_rv,
              vecs[i].exp_pc, 1'b0);
    end

    // Immediate exception: flush in the accepting cycle plus one FLUSH cycle.
    step();
    idle_inputs();
    exc_req    = 1'b1;
    exc_vector = 32'hBFC00380;
    settle();
    chk_out("exc.c0", 5'b0, 5'b11111, 1'b1, 32'hBFC00380, 1'b0);
    step();
    idle_inputs();
    settle();
    chk_out("exc.c1", 5'b0, 5'b11111, 1'b0, 32'hBFC00380, 1'b1);
    step();
    settle();
    chk_out("exc.c2", 5'b0, 5'b0, 1'b0, 32'hBFC00380, 1'b0);

    // Priority: exception beats ERET and branch; requests ignored in FLUSH.
    step();
    exc_req     = 1'b1;
    exc_vector  = 32'h80000180;
    eret_req    = 1'b1;
    epc         = 32'h12345678;
    br_redirect = 1'b1;
    br_target   = 32'h80001000;
    settle();
    chk_out("prio.c0", 5'b0, 5'b11111, 1'b1, 32'h80000180, 1'b0);
    step();
    exc_vector = 32'hDEADBEEF;
    settle();
    chk_out("prio.c1", 5'b0, 5'b11111, 1'b0, 32'h80000180, 1'b1);
    step();
    idle_inputs();
    settle();
    chk("prio.idle", 32'(busy), 32'h0);

    // ERET alone returns to epc.
    step();
    eret_req = 1'b1;
    epc      = 32'h00400100;
    settle();
    chk_out("eret.c0", 5'b0, 5'b11111, 1'b1, 32'h00400100, 1'b0);
    step();
    idle_inputs();
    step();
    settle();
    chk("eret.idle", 32'(busy), 32'h0);

    // Deferred exception: MEM stalls for three cycles, then FLUSH.
    step();
    exc_req    = 1'b1;
    exc_vector = 32'hBFC00200;
    stall_req  = 5'b01000;
    settle();
    chk("dfr.c0.rv", 32'(redirect_valid), 32'h0);
    chk("dfr.c0.flush", 32'(flush), 32'h0);
    step();
    exc_vector = 32'hDEADBEEF;
    eret_req   = 1'b1;
    settle();
    chk_out("dfr.c1", 5'b11111, 5'b0, 1'b0, 32'hBFC00200, 1'b1);
    step();
    settle();
    chk_out("dfr.c2", 5'b11111, 5'b0, 1'b0, 32'hBFC00200, 1'b1);
    step();
    stall_req = 5'b0;
    exc_req   = 1'b0;
    eret_req  = 1'b0;
    settle();
    chk_out("dfr.c3", 5'b0, 5'b11111, 1'b1, 32'hBFC00200, 1'b1);
    step();
    settle();
    chk_out("dfr.c4", 5'b0, 5'b11111, 1'b0, 32'hBFC00200, 1'b1);
    step();
    idle_inputs();
    settle();
    chk_out("dfr.c5", 5'b0, 5'b0, 1'b0, 32'hBFC00200, 1'b0);

`ifdef PIPE_HAZARD_PERF_EN
    chk("perf.flush", perf_flush_cnt, 32'd4);
    chk("perf.redir", perf_redirect_cnt, 32'd2);
`endif

    // Reset mid-FLUSH.
    step();
    exc_req    = 1'b1;
    exc_vector = 32'hA0000000;
    step();
    exc_req = 1'b0;
    rst     = 1'b1;
    settle();
    chk("rstf.flush", 32'(flush), 32'h0);
    chk("rstf.rv", 32'(redirect_valid), 32'h0);
    step();
    rst = 1'b0;
    settle();
    chk_out("rstf.after", 5'b0, 5'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("rstf.perf_stall", perf_stall_cnt, 32'h0);
    chk("rstf.perf_flush", perf_flush_cnt, 32'h0);
    chk("rstf.perf_redir", perf_redirect_cnt, 32'h0);
`endif

    // Reset mid-WAIT discards the pending redirect.
    step();
    exc_req    = 1'b1;
    exc_vector = 32'hBFC00400;
    stall_req  = 5'b10000;
    step();
    exc_req = 1'b0;
    settle();
    chk("rstw.busy_wait", 32'(busy), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk_out("rstw.after", 5'b11111, 5'b0, 1'b0, 32'h0, 1'b0);
    step();
    stall_req = 5'b0;
    settle();
    chk_out("rstw.nopend", 5'b0, 5'b0, 1'b0, 32'h0, 1'b0);
    step();
    settle();
    chk_out("rstw.still", 5'b0, 5'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
